// File: rtl/card_count_tracker_if.sv
// Classifier-to-tracker card handshake.
// One 4-bit card rank per valid/ready transfer.
interface card_count_tracker_if;
    logic       cls_valid;
    logic [3:0] cls_rank;
    logic       cls_ready;

    modport master (
        output cls_valid,
        output cls_rank,
        input  cls_ready
    );

    modport slave (
        input  cls_valid,
        input  cls_rank,
        output cls_ready
    );
endinterface

// File: rtl/card_count_tracker.sv
// Hi-Lo running count, shoe tracking and true count.
// True count comes from a bit-serial restoring divider.
module card_count_tracker #(
    parameter int NUM_DECKS = 6,
    parameter int COUNT_W   = 8,
    parameter int SEEN_W    = $clog2(52*NUM_DECKS+1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    card_count_tracker_if.slave       cls,
    input  logic                      shoe_clear,
    output logic signed [COUNT_W-1:0] running_count,
    output logic signed [COUNT_W-1:0] true_count,
    output logic                      tc_valid,
    output logic [SEEN_W-1:0]         cards_seen,
    output logic                      shoe_empty,
    output logic                      card_drop
);
    localparam int TOTAL = 52*NUM_DECKS;
    localparam int DR_W  = $clog2(NUM_DECKS+1);
    localparam int MAG_W = COUNT_W+1;
    localparam int CNT_W = $clog2(COUNT_W);

    localparam logic signed [MAG_W-1:0] SMAX =
        {2'b00, {(COUNT_W-1){1'b1}}};
    localparam logic signed [MAG_W-1:0] SMIN =
        {2'b11, {(COUNT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT_W-1);

    typedef enum logic {IDLE, DIV} state_t;

    state_t             state;
    logic [DR_W-1:0]    decks_rem;
    logic [5:0]         m52;
    logic [CNT_W-1:0]   cnt;
    logic [MAG_W-1:0]   rem_q;
    logic [COUNT_W-1:0] dvd_q;
    logic [MAG_W-1:0]   dvs_q;
    logic               neg_q;
    logic               qtop_q;

    function automatic logic signed [COUNT_W-1:0] sat(
        input logic signed [MAG_W-1:0] v
    );
        if (v > SMAX)
            return SMAX[COUNT_W-1:0];
        else if (v < SMIN)
            return SMIN[COUNT_W-1:0];
        else
            return v[COUNT_W-1:0];
    endfunction

    logic [3:0] rank;
    logic       accept;
    logic       is_card;
    logic       counted;
    logic       dropped;

    assign cls.cls_ready = (state == IDLE) && !shoe_clear;
    assign rank          = cls.cls_rank;
    assign accept        = cls.cls_valid && cls.cls_ready;
    assign is_card       = (rank >= 4'd1) && (rank <= 4'd13);
    assign shoe_empty    = cards_seen == SEEN_W'(TOTAL);
    assign counted       = accept && is_card && !shoe_empty;
    assign dropped       = accept && ((rank >= 4'd14) ||
                                      (is_card && shoe_empty));

    logic signed [MAG_W-1:0] wt;
    always_comb begin
        wt = '0;
        unique case (1'b1)
            (rank >= 4'd2 && rank <= 4'd6): wt = MAG_W'(1);
            (rank >= 4'd7 && rank <= 4'd9): wt = '0;
            default:                        wt = '1;
        endcase
    end

    logic signed [COUNT_W-1:0] rc_next;
    logic [MAG_W-1:0]          rc_ext;
    logic [MAG_W-1:0]          mag;
    logic [DR_W-1:0]           dr_next;
    logic [5:0]                m52_next;
    logic [MAG_W-1:0]          dvs;
    logic                      q_top;

    always_comb begin
        rc_next  = sat({running_count[COUNT_W-1], running_count} + wt);
        rc_ext   = {rc_next[COUNT_W-1], rc_next};
        mag      = rc_next[COUNT_W-1] ? (~rc_ext + MAG_W'(1)) : rc_ext;
        m52_next = (m52 == 6'd51) ? 6'd0 : m52 + 6'd1;
        dr_next  = (m52 == 6'd51) ? decks_rem - DR_W'(1) : decks_rem;
        dvs      = (dr_next == '0) ? MAG_W'(1) : MAG_W'(dr_next);
        // The magnitude bit above COUNT_W resolves before iterating.
        q_top    = mag[COUNT_W] && (dvs == MAG_W'(1));
    end

    logic [MAG_W-1:0]          rem_sh;
    logic                      qbit;
    logic [MAG_W-1:0]          rem_nx;
    logic [COUNT_W-1:0]        dvd_nx;
    logic [MAG_W-1:0]          q_full;
    logic signed [MAG_W-1:0]   q_s;

    always_comb begin
        rem_sh = {rem_q[MAG_W-2:0], dvd_q[COUNT_W-1]};
        qbit   = rem_q[MAG_W-1] || (rem_sh >= dvs_q);
        rem_nx = qbit ? rem_sh - dvs_q : rem_sh;
        dvd_nx = {dvd_q[COUNT_W-2:0], qbit};
        q_full = {qtop_q, dvd_nx};
        q_s    = neg_q ? $signed(~q_full + MAG_W'(1))
                       : $signed(q_full);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            running_count <= '0;
            true_count    <= '0;
            tc_valid      <= 1'b1;
            cards_seen    <= '0;
            decks_rem     <= DR_W'(NUM_DECKS);
            m52           <= '0;
            card_drop     <= 1'b0;
            cnt           <= '0;
            rem_q         <= '0;
            dvd_q         <= '0;
            dvs_q         <= MAG_W'(1);
            neg_q         <= 1'b0;
            qtop_q        <= 1'b0;
        end else if (shoe_clear) begin
            state         <= IDLE;
            running_count <= '0;
            true_count    <= '0;
            tc_valid      <= 1'b1;
            cards_seen    <= '0;
            decks_rem     <= DR_W'(NUM_DECKS);
            m52           <= '0;
            card_drop     <= 1'b0;
            cnt           <= '0;
        end else begin
            card_drop <= dropped;
            unique case (state)
                IDLE: begin
                    if (counted) begin
                        running_count <= rc_next;
                        cards_seen    <= cards_seen + SEEN_W'(1);
                        decks_rem     <= dr_next;
                        m52           <= m52_next;
                        tc_valid      <= 1'b0;
                        cnt           <= '0;
                        dvs_q         <= dvs;
                        neg_q         <= rc_next[COUNT_W-1];
                        qtop_q        <= q_top;
                        rem_q         <= MAG_W'(mag[COUNT_W] && !q_top);
                        dvd_q         <= mag[COUNT_W-1:0];
                        state         <= DIV;
                    end
                end
                DIV: begin
                    rem_q <= rem_nx;
                    dvd_q <= dvd_nx;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        true_count <= sat(q_s);
                        tc_valid   <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_card_count_tracker.sv
// Directed bench for card_count_tracker.
// Three shoe sizes share one stimulus bus selected by sel.
module tb_card_count_tracker;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] rank = 4'd0;
    logic [1:0] sel = 2'd0;
    int         n_err = 0;
    int         n_chk = 0;

    always #5 clk = ~clk;

    card_count_tracker_if if_a ();
    card_count_tracker_if if_b ();
    card_count_tracker_if if_c ();

    assign if_a.cls_valid = valid && (sel == 2'd0);
    assign if_b.cls_valid = valid && (sel == 2'd1);
    assign if_c.cls_valid = valid && (sel == 2'd2);
    assign if_a.cls_rank  = rank;
    assign if_b.cls_rank  = rank;
    assign if_c.cls_rank  = rank;

    logic signed [7:0] rc_a, rc_b, rc_c, tc_a, tc_b, tc_c;
    logic [6:0] seen_a;
    logic [8:0] seen_b;
    logic [5:0] seen_c;
    logic tv_a, tv_b, tv_c, em_a, em_b, em_c, dr_a, dr_b, dr_c;

    card_count_tracker #(.NUM_DECKS(2), .COUNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .cls(if_a.slave),
        .shoe_clear(clear && (sel == 2'd0)),
        .running_count(rc_a), .true_count(tc_a), .tc_valid(tv_a),
        .cards_seen(seen_a), .shoe_empty(em_a), .card_drop(dr_a)
    );

    card_count_tracker #(.NUM_DECKS(6), .COUNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .cls(if_b.slave),
        .shoe_clear(clear && (sel == 2'd1)),
        .running_count(rc_b), .true_count(tc_b), .tc_valid(tv_b),
        .cards_seen(seen_b), .shoe_empty(em_b), .card_drop(dr_b)
    );

    card_count_tracker #(.NUM_DECKS(1), .COUNT_W(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .cls(if_c.slave),
        .shoe_clear(clear && (sel == 2'd2)),
        .running_count(rc_c), .true_count(tc_c), .tc_valid(tv_c),
        .cards_seen(seen_c), .shoe_empty(em_c), .card_drop(dr_c)
    );

    logic signed [7:0] o_rc, o_tc;
    logic [8:0] o_seen;
    logic o_tcv, o_empty, o_drop, o_ready;

    always_comb begin
        o_rc = rc_a; o_tc = tc_a; o_seen = 9'(seen_a);
        o_tcv = tv_a; o_empty = em_a; o_drop = dr_a;
        o_ready = if_a.cls_ready;
        unique case (sel)
            2'd1: begin
                o_rc = rc_b; o_tc = tc_b; o_seen = seen_b;
                o_tcv = tv_b; o_empty = em_b; o_drop = dr_b;
                o_ready = if_b.cls_ready;
            end
            2'd2: begin
                o_rc = rc_c; o_tc = tc_c; o_seen = 9'(seen_c);
                o_tcv = tv_c; o_empty = em_c; o_drop = dr_c;
                o_ready = if_c.cls_ready;
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag,
                       input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic feed(input logic [3:0] r);
        int n = 0;
        @(negedge clk);
        while (!o_ready && n < 64) begin
            n++;
            @(negedge clk);
        end
        if (!o_ready) chk("ready_wait", 0, 1);
        valid = 1'b1;
        rank  = r;
        @(posedge clk);
        #1 valid = 1'b0;
    endtask

    task automatic settle();
        int n = 0;
        @(negedge clk);
        while (!(o_ready && o_tcv) && n < 64) begin
            n++;
            @(negedge clk);
        end
        if (!(o_ready && o_tcv)) chk("settle_wait", 0, 1);
    endtask

    task automatic lat();
        int n = 0;
        @(negedge clk);
        while (!o_tcv && n < 64) begin
            n++;
            @(negedge clk);
        end
        chk("tc_latency", n, 8);
    endtask

    task automatic clr();
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_rc", o_rc, 0);
        chk("rst_tc", o_tc, 0);
        chk("rst_tcv", o_tcv, 1);
        chk("rst_seen", o_seen, 0);
        chk("rst_empty", o_empty, 0);
        chk("rst_drop", o_drop, 0);
        chk("rst_ready", o_ready, 1);

        // two decks: +10 then a king
        feed(4'd5);
        lat();
        for (int i = 0; i < 9; i++) feed(4'd5);
        settle();
        chk("a_rc10", o_rc, 10);
        chk("a_seen10", o_seen, 10);
        chk("a_tc5", o_tc, 5);
        feed(4'd13);
        lat();
        chk("a_rc9", o_rc, 9);
        chk("a_tc4", o_tc, 4);
        chk("a_seen11", o_seen, 11);

        clr();
        @(negedge clk);
        chk("clr_rc", o_rc, 0);
        chk("clr_seen", o_seen, 0);
        chk("clr_tcv", o_tcv, 1);
        chk("clr_tc", o_tc, 0);

        for (int i = 0; i < 7; i++) feed(4'd1);
        settle();
        chk("a_rcm7", o_rc, -7);
        chk("a_tcm3", o_tc, -3);
        feed(4'd8);
        settle();
        chk("a_rc8", o_rc, -7);
        chk("a_seen8", o_seen, 8);
        chk("a_tc8", o_tc, -3);

        feed(4'd0);
        @(negedge clk);
        chk("r0_drop", o_drop, 0);
        chk("r0_ready", o_ready, 1);
        feed(4'd14);
        @(negedge clk);
        chk("r14_drop", o_drop, 1);
        chk("r14_ready", o_ready, 1);
        @(negedge clk);
        chk("r14_drop_end", o_drop, 0);
        feed(4'd15);
        @(negedge clk);
        chk("r15_drop", o_drop, 1);
        chk("inv_rc", o_rc, -7);
        chk("inv_seen", o_seen, 8);

        // clear while the divider is busy
        feed(4'd2);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("busy_ready", o_ready, 0);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        chk("mid_rc", o_rc, 0);
        chk("mid_seen", o_seen, 0);
        chk("mid_tcv", o_tcv, 1);
        chk("mid_tc", o_tc, 0);
        chk("mid_ready", o_ready, 1);

        @(negedge clk);
        clear = 1'b1;
        valid = 1'b1;
        rank  = 4'd3;
        #1 chk("co_ready", o_ready, 0);
        @(posedge clk);
        #1 begin clear = 1'b0; valid = 1'b0; end
        @(negedge clk);
        chk("co_seen", o_seen, 0);
        chk("co_rc", o_rc, 0);
        chk("co_tcv", o_tcv, 1);
        feed(4'd3);
        feed(4'd3);
        settle();
        chk("co_rc2", o_rc, 2);
        chk("co_tc1", o_tc, 1);
        chk("co_seen2", o_seen, 2);

        // six decks: saturation and decks remaining
        sel = 2'd1;
        for (int i = 0; i < 130; i++) feed(4'd2);
        settle();
        chk("b_rc127", o_rc, 127);
        chk("b_seen130", o_seen, 130);
        chk("b_dr4", dut_b.decks_rem, 4);
        chk("b_tc31", o_tc, 31);
        chk("b_empty", o_empty, 0);

        // single deck: empty shoe and divisor of one
        sel = 2'd2;
        for (int i = 0; i < 52; i++) feed(4'd7);
        settle();
        chk("c_empty", o_empty, 1);
        chk("c_seen52", o_seen, 52);
        chk("c_dr0", dut_c.decks_rem, 0);
        chk("c_rc0", o_rc, 0);
        feed(4'd3);
        @(negedge clk);
        chk("c_drop", o_drop, 1);
        settle();
        chk("c_seen_hold", o_seen, 52);
        chk("c_rc_hold", o_rc, 0);

        clr();
        for (int i = 0; i < 51; i++) feed(4'd2);
        settle();
        chk("c_rc51", o_rc, 51);
        chk("c_tc51", o_tc, 51);
        chk("c_empty51", o_empty, 0);
        feed(4'd10);
        settle();
        chk("c_rc50", o_rc, 50);
        chk("c_tc50", o_tc, 50);
        chk("c_empty52", o_empty, 1);
        feed(4'd3);
        @(negedge clk);
        chk("c_drop2", o_drop, 1);
        chk("c_rc50b", o_rc, 50);

        // asynchronous reset mid-division
        clr();
        feed(4'd4);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_rc", o_rc, 0);
        chk("ar_tc", o_tc, 0);
        chk("ar_tcv", o_tcv, 1);
        chk("ar_seen", o_seen, 0);
        chk("ar_ready", o_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_tcv2", o_tcv, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
